// File: rtl/clint_timer.sv
// Machine-mode core-local interruptor: mtime, mtimecmp and msip behind a
// single-outstanding valid/ready slave port, driving mip_msip / mip_mtip.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        rtc_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mip_msip,
    output logic        mip_mtip
);

    localparam logic [15:0] ADDR_MSIP    = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO  = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI  = 16'h4004;
    localparam logic [15:0] ADDR_TIME_LO = 16'hBFF8;
    localparam logic [15:0] ADDR_TIME_HI = 16'hBFFC;
    localparam logic [15:0] DIV_LAST     = 16'(TICK_DIV - 1);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [15:0] r_div_cnt;
    logic        r_mtip;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_wr;
    logic        w_tick;
    logic        w_div_wrap;
    logic        w_sel_msip;
    logic        w_sel_cmp_lo;
    logic        w_sel_cmp_hi;
    logic        w_sel_time_lo;
    logic        w_sel_time_hi;
    logic        w_hit;
    logic [31:0] w_rdata;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_mtimecmp_nxt;

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_wr      = w_accept && req_wr;

    // Full-address compare also rejects any misaligned offset.
    assign w_sel_msip    = (req_addr == ADDR_MSIP);
    assign w_sel_cmp_lo  = (req_addr == ADDR_CMP_LO);
    assign w_sel_cmp_hi  = (req_addr == ADDR_CMP_HI);
    assign w_sel_time_lo = (req_addr == ADDR_TIME_LO);
    assign w_sel_time_hi = (req_addr == ADDR_TIME_HI);
    assign w_hit = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi
                 | w_sel_time_lo | w_sel_time_hi;

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_msip:    w_rdata = {31'd0, r_msip};
            w_sel_cmp_lo:  w_rdata = r_mtimecmp[31:0];
            w_sel_cmp_hi:  w_rdata = r_mtimecmp[63:32];
            w_sel_time_lo: w_rdata = r_mtime[31:0];
            w_sel_time_hi: w_rdata = r_mtime[63:32];
            default:       w_rdata = '0;
        endcase
    end

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_tick     = rtc_en && w_div_wrap;

    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            r_div_cnt <= '0;
        end else if (rtc_en) begin
            r_div_cnt <= w_div_wrap ? 16'd0 : r_div_cnt + 16'd1;
        end
    end

    // A bus write to either half swallows the tick of that cycle.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr && w_sel_time_lo) begin
            w_mtime_nxt[31:0] = req_wdata;
        end else if (w_wr && w_sel_time_hi) begin
            w_mtime_nxt[63:32] = req_wdata;
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr && w_sel_cmp_lo) begin
            w_mtimecmp_nxt[31:0] = req_wdata;
        end else if (w_wr && w_sel_cmp_hi) begin
            w_mtimecmp_nxt[63:32] = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_mtip     <= (r_mtime >= r_mtimecmp);
            if (w_wr && w_sel_msip) begin
                r_msip <= req_wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_hit;
            r_rsp_rdata <= req_wr ? 32'd0 : w_rdata;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mip_msip  = r_msip;
    assign mip_mtip  = r_mtip;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: per-cycle reference model plus directed
// register, timer, handshake and collision scenarios.
module tb_clint_timer;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        cpurst_n = 1'b0;
    logic        rtc_en = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mip_msip;
    logic        mip_mtip;

    int n_cmp = 0;
    int n_fail = 0;
    int n_acc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    clint_timer #(.TICK_DIV(N)) dut (
        .clk       (clk),
        .cpurst_n  (cpurst_n),
        .rtc_en    (rtc_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mip_msip  (mip_msip),
        .mip_mtip  (mip_mtip)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural registers plus a count of enabled
    // cycles; a tick falls on every N-th enabled cycle since reset.
    logic [63:0]     m_time;
    logic [63:0]     m_cmp;
    logic            m_msip;
    logic            m_mtip;
    logic            m_rv;
    logic            m_err;
    logic [31:0]     m_rdata;
    longint unsigned m_en_cycles;

    function automatic logic [32:0] m_read(input logic [15:0] a);
        case (a)
            16'h0000: return {1'b0, 31'd0, m_msip};
            16'h4000: return {1'b0, m_cmp[31:0]};
            16'h4004: return {1'b0, m_cmp[63:32]};
            16'hBFF8: return {1'b0, m_time[31:0]};
            16'hBFFC: return {1'b0, m_time[63:32]};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    always @(posedge clk) begin
        logic        acc;
        logic        tick;
        logic        ge;
        logic        twr;
        logic [32:0] rd;
        if (!cpurst_n) begin
            m_time = 64'd0;
            m_cmp = '1;
            m_msip = 1'b0;
            m_mtip = 1'b0;
            m_rv = 1'b0;
            m_err = 1'b0;
            m_rdata = 32'd0;
            m_en_cycles = 0;
        end else begin
            acc = req_valid && (!m_rv || rsp_ready);
            tick = 1'b0;
            twr = 1'b0;
            if (rtc_en) begin
                m_en_cycles++;
                tick = (m_en_cycles % N) == 0;
            end
            ge = m_time >= m_cmp;
            rd = m_read(req_addr);
            if (acc) begin
                m_rv = 1'b1;
                m_err = rd[32];
                m_rdata = req_wr ? 32'd0 : rd[31:0];
            end else if (rsp_ready) begin
                m_rv = 1'b0;
            end
            if (acc && req_wr && !rd[32]) begin
                case (req_addr)
                    16'h0000: m_msip = req_wdata[0];
                    16'h4000: m_cmp[31:0] = req_wdata;
                    16'h4004: m_cmp[63:32] = req_wdata;
                    16'hBFF8: begin m_time[31:0] = req_wdata; twr = 1'b1; end
                    16'hBFFC: begin m_time[63:32] = req_wdata; twr = 1'b1; end
                    default: ;
                endcase
            end
            if (tick && !twr) m_time = m_time + 64'd1;
            m_mtip = ge;
        end
    end

    always @(posedge clk) begin
        if (cpurst_n && req_valid && req_ready) n_acc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", req_ready, !m_rv || rsp_ready);
            check("rsp_valid", rsp_valid, m_rv);
            check("mip_msip", mip_msip, m_msip);
            check("mip_mtip", mip_mtip, m_mtip);
            if (m_rv) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic bus(input logic wr, input logic [15:0] a,
                       input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_wr = 1'b0;
        rd = rsp_rdata;
        er = rsp_err;
        check("bus_rsp_valid", rsp_valid, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        req_valid = 1'b0;
        cpurst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cpurst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          a0;

        // reset held for 3 edges
        @(posedge clk); #2;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        cpurst_n = 1'b1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_mtip", mip_mtip, 1'b0);
        check("rst_msip", mip_msip, 1'b0);
        bus(1'b0, 16'h4000, 32'd0, rd, er);
        check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        check("rst_cmp_err", er, 1'b0);

        // software interrupt
        bus(1'b1, 16'h0000, 32'hFFFF_FFFF, rd, er);
        check("msip_set", mip_msip, 1'b1);
        check("msip_wr_rdata", rd, 32'd0);
        bus(1'b0, 16'h0000, 32'd0, rd, er);
        check("msip_rd", rd, 32'd1);
        bus(1'b1, 16'h0000, 32'd0, rd, er);
        check("msip_clr", mip_msip, 1'b0);

        // carry: 8 enabled cycles hold exactly 2 ticks
        bus(1'b1, 16'hBFFC, 32'd0, rd, er);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, rd, er);
        @(posedge clk); #2;
        rtc_en = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rtc_en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'd0, rd, er);
        check("carry_lo", rd, 32'd0);
        bus(1'b0, 16'hBFFC, 32'd0, rd, er);
        check("carry_hi", rd, 32'd1);

        // timer interrupt from mtime=0
        do_reset();
        bus(1'b1, 16'h4004, 32'd0, rd, er);
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_addr = 16'h4000;
        req_wdata = 32'd10;
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_wr = 1'b0;
        rtc_en = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("mtip_edge40", mip_mtip, 1'b0);
        @(posedge clk); #2;
        check("mtip_edge41", mip_mtip, 1'b1);
        bus(1'b1, 16'h4000, 32'd20, rd, er);
        check("mtip_acc", mip_mtip, 1'b1);
        @(posedge clk); #2;
        check("mtip_clr1", mip_mtip, 1'b0);
        @(posedge clk); #2;
        check("mtip_clr2", mip_mtip, 1'b0);
        rtc_en = 1'b0;

        // errors
        bus(1'b1, 16'h0004, 32'd1, rd, er);
        check("err_0004", er, 1'b1);
        check("err_0004_rd", rd, 32'd0);
        check("err_msip", mip_msip, 1'b0);
        bus(1'b1, 16'h4001, 32'd5, rd, er);
        check("err_4001w", er, 1'b1);
        bus(1'b0, 16'h4001, 32'd0, rd, er);
        check("err_4001r", er, 1'b1);
        check("err_4001r_rd", rd, 32'd0);
        bus(1'b0, 16'h4000, 32'd0, rd, er);
        check("cmp_kept", rd, 32'd20);

        // backpressure
        bus(1'b1, 16'hBFF8, 32'h1234_5678, rd, er);
        @(posedge clk); #2;
        a0 = n_acc;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = 16'hBFF8;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rdata", rsp_rdata, 32'h1234_5678);
        end
        check("bp_accepts", n_acc - a0, 1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_drain", rsp_valid, 1'b0);

        // reset with a response pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 16'h4000;
        @(posedge clk); #2;
        check("mid_pending", rsp_valid, 1'b1);
        do_reset();
        check("mid_dropped", rsp_valid, 1'b0);
        rsp_ready = 1'b1;

        // mtime write on the tick cycle
        rtc_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_addr = 16'hBFF8;
        req_wdata = 32'h100;
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_wr = 1'b0;
        rtc_en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'd0, rd, er);
        check("coll_lo", rd, 32'h100);
        rtc_en = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rtc_en = 1'b0;
        bus(1'b0, 16'hBFF8, 32'd0, rd, er);
        check("coll_next", rd, 32'h101);

        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
